// File: rtl/teclado_pkg.sv
// Shared PS/2 scan-code constants and the dialogue state encoding used by
// the keyboard sequencer and the gain decoder.
package teclado_pkg;

    // Set-2 make codes of the keys taking part in the gain dialogue
    localparam logic [7:0] TECLA_G           = 8'h34;
    localparam logic [7:0] TECLA_ENTER       = 8'h5A;
    localparam logic [7:0] TECLA_ESC         = 8'h76;
    localparam logic [7:0] TECLA_0           = 8'h45;
    localparam logic [7:0] TECLA_1           = 8'h16;
    localparam logic [7:0] TECLA_2           = 8'h1E;
    localparam logic [7:0] TECLA_3           = 8'h26;

    // Prefix bytes: break (key release) and extended key
    localparam logic [7:0] PREFIJO_RUPTURA   = 8'hF0;
    localparam logic [7:0] PREFIJO_EXTENDIDO = 8'hE0;

    // Dialogue states
    typedef enum logic [2:0] {
        ESPERA       = 3'd0,
        SEL_GANANCIA = 3'd1,
        SEL_VALOR    = 3'd2,
        CONFIRMA     = 3'd3,
        GUARDA       = 3'd4
    } estado_t;

    // True for the keys that may be stored as a gain value (0..3)
    function automatic logic es_tecla_valor(input logic [7:0] codigo);
        return (codigo == TECLA_0) || (codigo == TECLA_1) ||
               (codigo == TECLA_2) || (codigo == TECLA_3);
    endfunction

    // Gain selector for keys 1..3, zero for anything else
    function automatic logic [1:0] ganancia_de_tecla(input logic [7:0] codigo);
        logic [1:0] g;
        g = 2'd0;
        case (codigo)
            TECLA_1: g = 2'd1;
            TECLA_2: g = 2'd2;
            TECLA_3: g = 2'd3;
            default: g = 2'd0;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/temporizador_espera.sv
// Inactivity timer for the keyboard dialogue: counts enabled cycles and
// ticks expiro while the count sits on its last value.
module temporizador_espera #(
    parameter int TIMEOUT_CICLOS = 250_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic habilitar,
    input  logic limpiar,
    output logic expiro
);

    localparam int ANCHO = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
    localparam logic [ANCHO-1:0] ULTIMO = ANCHO'(TIMEOUT_CICLOS - 1);

    logic [ANCHO-1:0] cuenta;

    // Count idle cycles while enabled; any clear or leaving the dialogue restarts from zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cuenta <= '0;
        end else if (limpiar || !habilitar) begin
            cuenta <= '0;
        end else if (cuenta != ULTIMO) begin
            cuenta <= cuenta + 1'b1;
        end
    end

    assign expiro = habilitar && (cuenta == ULTIMO);

endmodule

// File: rtl/control_teclado_ganancias.sv
// Keyboard-entry sequencer: filters PS/2 break/extended prefixes and runs the
// G -> gain -> value -> Enter dialogue, strobing salvar on confirmation.
module control_teclado_ganancias
    import teclado_pkg::*;
#(
    parameter int TIMEOUT_CICLOS = 250_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_dato,
    input  logic       rx_listo,
    output logic [7:0] dato_tecla,
    output logic [1:0] estado_tipo_dato,
    output logic       salvar,
    output logic       ocupado,
    output logic       fin_tiempo
);

    estado_t    estado;
    estado_t    estado_sig;
    logic [1:0] tipo_sig;
    logic [7:0] dato_sig;
    logic       fin_sig;

    logic       descartar;
    logic       es_make;
    logic       tmp_habilitar;
    logic       tmp_limpiar;
    logic       tmp_expiro;

    // A byte is a make code unless it is a prefix or follows a break prefix
    assign es_make = rx_listo && !descartar &&
                     (rx_dato != PREFIJO_RUPTURA) &&
                     (rx_dato != PREFIJO_EXTENDIDO);

    // Break flag: set by F0, cleared by whatever byte follows it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            descartar <= 1'b0;
        end else if (rx_listo) begin
            descartar <= (rx_dato == PREFIJO_RUPTURA);
        end
    end

    assign tmp_habilitar = (estado == SEL_GANANCIA) ||
                           (estado == SEL_VALOR)    ||
                           (estado == CONFIRMA);
    assign tmp_limpiar   = es_make || (estado_sig != estado);

    temporizador_espera #(
        .TIMEOUT_CICLOS (TIMEOUT_CICLOS)
    ) u_temporizador (
        .clk       (clk),
        .rst       (rst),
        .habilitar (tmp_habilitar),
        .limpiar   (tmp_limpiar),
        .expiro    (tmp_expiro)
    );

    // Dialogue next-state and register updates; a make code always beats an expiring timer
    always_comb begin
        estado_sig = estado;
        tipo_sig   = estado_tipo_dato;
        dato_sig   = dato_tecla;
        fin_sig    = 1'b0;

        case (estado)
            ESPERA: begin
                if (es_make && (rx_dato == TECLA_G)) begin
                    estado_sig = SEL_GANANCIA;
                end
            end

            SEL_GANANCIA: begin
                if (es_make) begin
                    if (rx_dato == TECLA_ESC) begin
                        estado_sig = ESPERA;
                    end else if (ganancia_de_tecla(rx_dato) != 2'd0) begin
                        tipo_sig   = ganancia_de_tecla(rx_dato);
                        estado_sig = SEL_VALOR;
                    end
                end else if (tmp_expiro) begin
                    estado_sig = ESPERA;
                    fin_sig    = 1'b1;
                end
            end

            SEL_VALOR: begin
                if (es_make) begin
                    if (rx_dato == TECLA_ESC) begin
                        estado_sig = ESPERA;
                    end else if (es_tecla_valor(rx_dato)) begin
                        dato_sig   = rx_dato;
                        estado_sig = CONFIRMA;
                    end
                end else if (tmp_expiro) begin
                    estado_sig = ESPERA;
                    fin_sig    = 1'b1;
                end
            end

            CONFIRMA: begin
                if (es_make) begin
                    if (rx_dato == TECLA_ESC) begin
                        estado_sig = ESPERA;
                    end else if (rx_dato == TECLA_ENTER) begin
                        estado_sig = GUARDA;
                    end else if (es_tecla_valor(rx_dato)) begin
                        dato_sig   = rx_dato;
                    end
                end else if (tmp_expiro) begin
                    estado_sig = ESPERA;
                    fin_sig    = 1'b1;
                end
            end

            GUARDA: begin
                estado_sig = ESPERA;
            end

            default: begin
                estado_sig = ESPERA;
            end
        endcase

        if (estado_sig == ESPERA) begin
            tipo_sig = 2'd0;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            estado           <= ESPERA;
            estado_tipo_dato <= 2'd0;
            dato_tecla       <= 8'h00;
            fin_tiempo       <= 1'b0;
        end else begin
            estado           <= estado_sig;
            estado_tipo_dato <= tipo_sig;
            dato_tecla       <= dato_sig;
            fin_tiempo       <= fin_sig;
        end
    end

    assign salvar  = (estado == GUARDA);
    assign ocupado = (estado != ESPERA);

endmodule

// File: tb/tb_control_teclado_ganancias.sv
// Scoreboard bench for control_teclado_ganancias: a behavioural model of the
// key dialogue predicts store/timeout events and the visible outputs.
module tb_control_teclado_ganancias;

    localparam int T = 16;

    logic       clk;
    logic       rst;
    logic [7:0] rx_dato;
    logic       rx_listo;
    logic [7:0] dato_tecla;
    logic [1:0] estado_tipo_dato;
    logic       salvar;
    logic       ocupado;
    logic       fin_tiempo;

    control_teclado_ganancias #(
        .TIMEOUT_CICLOS (T)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .rx_dato          (rx_dato),
        .rx_listo         (rx_listo),
        .dato_tecla       (dato_tecla),
        .estado_tipo_dato (estado_tipo_dato),
        .salvar           (salvar),
        .ocupado          (ocupado),
        .fin_tiempo       (fin_tiempo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected events: kind 0 = store (with gain/value), kind 1 = timeout
    typedef struct {
        int kind;
        int tipo;
        int dato;
    } ev_t;
    ev_t sbq[$];

    typedef logic [7:0] byte_q_t[$];
    byte_q_t seq;

    int checks = 0;
    int passes = 0;

    // Reference model: dialogue step (0 idle, 1 wants gain, 2 wants value,
    // 3 wants Enter, 4 storing), chosen gain, last value, break flag, idle cycles
    int mStep  = 0;
    int mGain  = 0;
    int mVal   = 0;
    int mIdle  = 0;
    bit mBreak = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int gainOf(input logic [7:0] b);
        if (b == 8'h16) return 1;
        if (b == 8'h1E) return 2;
        if (b == 8'h26) return 3;
        return 0;
    endfunction

    function automatic bit isValue(input logic [7:0] b);
        return (b == 8'h45) || (gainOf(b) != 0);
    endfunction

    function automatic void modelReset();
        mStep  = 0;
        mGain  = 0;
        mVal   = 0;
        mIdle  = 0;
        mBreak = 1'b0;
        sbq.delete();
    endfunction

    // Advance the model by one clock edge given the byte offered at that edge
    function automatic void modelStep(input bit listo, input logic [7:0] b);
        bit   mk;
        ev_t  e;
        mk = listo && !mBreak && (b != 8'hF0) && (b != 8'hE0);
        if (listo) mBreak = (b == 8'hF0);

        if (mStep == 4) begin
            mStep = 0;
            mGain = 0;
        end else if (mStep == 0) begin
            if (mk && b == 8'h34) begin
                mStep = 1;
                mIdle = 0;
            end
        end else if (mk) begin
            mIdle = 0;
            if (b == 8'h76) begin
                mStep = 0;
                mGain = 0;
            end else if (mStep == 1 && gainOf(b) != 0) begin
                mGain = gainOf(b);
                mStep = 2;
            end else if (mStep == 2 && isValue(b)) begin
                mVal  = int'(b);
                mStep = 3;
            end else if (mStep == 3 && b == 8'h5A) begin
                e.kind = 0;
                e.tipo = mGain;
                e.dato = mVal;
                sbq.push_back(e);
                mStep = 4;
            end else if (mStep == 3 && isValue(b)) begin
                mVal = int'(b);
            end
        end else if (mIdle == T - 1) begin
            e.kind = 1;
            e.tipo = 0;
            e.dato = 0;
            sbq.push_back(e);
            mStep = 0;
            mGain = 0;
            mIdle = 0;
        end else begin
            mIdle++;
        end
    endfunction

    task automatic checkOutput();
        check("ocupado", int'(ocupado), int'(mStep != 0));
        check("estado_tipo_dato", int'(estado_tipo_dato), mGain);
        check("dato_tecla", int'(dato_tecla), mVal);
    endtask

    task automatic applyStimulus(input bit listo, input logic [7:0] b);
        @(negedge clk);
        rx_listo = listo;
        rx_dato  = listo ? b : 8'($urandom);
        modelStep(listo, b);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic sendSeq(input byte_q_t s);
        foreach (s[i]) applyStimulus(1'b1, s[i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00);
    endtask

    task automatic checkResetOutputs(input string tag);
        check({tag, " dato_tecla"}, int'(dato_tecla), 0);
        check({tag, " estado_tipo_dato"}, int'(estado_tipo_dato), 0);
        check({tag, " salvar"}, int'(salvar), 0);
        check({tag, " ocupado"}, int'(ocupado), 0);
        check({tag, " fin_tiempo"}, int'(fin_tiempo), 0);
    endtask

    // Monitor: every store or timeout pulse must match the oldest predicted event
    always @(negedge clk) begin
        if (rst && (salvar || fin_tiempo)) begin
            if (sbq.size() == 0) begin
                checks++;
                $display("[TB] FAIL unexpected event: salvar=%0b fin_tiempo=%0b, expected none at %0t",
                         salvar, fin_tiempo, $time);
            end else begin
                ev_t e;
                e = sbq.pop_front();
                check("event kind", salvar ? 0 : 1, e.kind);
                if (salvar) begin
                    check("salvar tipo", int'(estado_tipo_dato), e.tipo);
                    check("salvar dato", int'(dato_tecla), e.dato);
                end
            end
        end
    end

    // Stimulus: directed dialogues, mid-dialogue reset, then random byte streams
    initial begin
        logic [7:0] tabla [12];
        tabla = '{8'h34, 8'h16, 8'h1E, 8'h26, 8'h45, 8'h5A,
                  8'h76, 8'hF0, 8'hE0, 8'h34, 8'h5A, 8'h00};

        rst      = 1'b1;
        rx_listo = 1'b0;
        rx_dato  = 8'h00;
        #2 rst = 1'b0;
        #1 checkResetOutputs("reset");
        modelReset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        $display("[TB] test 1: full dialogue with break codes");
        seq = '{8'h34, 8'hF0, 8'h34, 8'h1E, 8'hF0, 8'h1E, 8'h26, 8'hF0, 8'h26, 8'h5A, 8'hF0, 8'h5A};
        sendSeq(seq);
        idle(3);

        $display("[TB] test 2: value changed while confirming");
        seq = '{8'h34, 8'h16, 8'h45, 8'h16, 8'h5A};
        sendSeq(seq);
        idle(3);

        $display("[TB] test 3: timeout");
        seq = '{8'h34, 8'h26};
        sendSeq(seq);
        idle(T + 4);

        $display("[TB] test 4: break-prefixed key ignored, Esc aborts");
        seq = '{8'h34, 8'hF0, 8'h16, 8'h16, 8'h45, 8'h76};
        sendSeq(seq);
        idle(3);

        $display("[TB] test 5: keypad Enter confirms");
        seq = '{8'h34, 8'h1E, 8'h45, 8'hE0, 8'h5A};
        sendSeq(seq);
        idle(3);

        $display("[TB] test 6: reset mid-dialogue");
        seq = '{8'h34, 8'h16, 8'h45};
        sendSeq(seq);
        #2 rst = 1'b0;
        #1 checkResetOutputs("mid reset");
        modelReset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        seq = '{8'h5A};
        sendSeq(seq);
        idle(3);

        $display("[TB] random streams");
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                idle(T + 2);
            end else begin
                int k;
                logic [7:0] b;
                k = int'($urandom_range(0, 11));
                b = (k == 11) ? 8'($urandom) : tabla[k];
                applyStimulus($urandom_range(0, 3) != 0, b);
            end
        end
        idle(T + 4);

        check("pending events", sbq.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/control_teclado_ganancias.md
# control_teclado_ganancias

Keyboard-entry sequencer sitting between the PS/2 byte receiver and the gain key decoder. Consumes raw scan-code bytes with a one-cycle ready tick, filters break and extended prefixes, and runs a G → gain-number → value → Enter dialogue. On confirmation it emits a one-cycle `salvar` pulse, holding a 2-bit gain selector and the value scan code stable, which the gain decoder uses to store one of its three 2-bit gains.

## Interface
- `TIMEOUT_CICLOS`, default 250_000_000: idle cycles allowed inside a dialogue before abort (5 s at 50 MHz); must be ≥ 2.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous and active-low.
- `rx_dato`  in  8  scan-code byte from the PS/2 receiver; valid only while `rx_listo`=1.
- `rx_listo`  in  1  one-cycle tick, one per received byte.
- `dato_tecla`  out  8  latched value scan code; feeds the decoder's data input.
- `estado_tipo_dato`  out  2  selected gain: 1, 2 or 3; 0 when no gain is selected.
- `salvar`  out  1  one-cycle store strobe.
- `ocupado`  out  1  high whenever the FSM is not in ESPERA.
- `fin_tiempo`  out  1  one-cycle pulse when a dialogue is aborted by timeout.

## Operation
- Scan codes (set 2): G=0x34, Enter=0x5A, Esc=0x76, 0=0x45, 1=0x16, 2=0x1E, 3=0x26, break prefix F0, extended prefix E0.
- Byte filter, applied before the FSM:
  - An F0 byte sets flag `descartar` and is consumed.
  - The next byte clears `descartar` and is consumed with no FSM action.
  - An E0 byte is consumed with no action, and the following byte is treated as a normal make code. This means keypad Enter (E0 5A) confirms.
  - Only make codes reach the FSM.
- FSM states:
  - **ESPERA**: G → SEL_GANANCIA. Any other code is ignored.
  - **SEL_GANANCIA**: 1/2/3 → `estado_tipo_dato`←1/2/3, go to SEL_VALOR. Other codes are ignored.
  - **SEL_VALOR**: 0/1/2/3 → `dato_tecla`←code, go to CONFIRMA. Other codes are ignored.
  - **CONFIRMA**: Enter → GUARDA. A value key (0–3) replaces `dato_tecla` and the FSM stays in CONFIRMA. Other codes are ignored.
  - **GUARDA**: `salvar`=1 (Moore output) for exactly one cycle, then unconditionally → ESPERA.
- Esc in SEL_GANANCIA, SEL_VALOR or CONFIRMA → ESPERA, with no `salvar`.
- On entry to ESPERA, `estado_tipo_dato` clears to 0. `dato_tecla` keeps its last value.
- Timeout:
  - The counter runs in SEL_GANANCIA, SEL_VALOR and CONFIRMA.
  - It clears on every make code delivered to the FSM, including ignored codes, and on every state change.
  - When it reaches TIMEOUT_CICLOS−1, the FSM goes to ESPERA and `fin_tiempo` pulses for one cycle.
  - If a make code arrives in the same cycle the count expires, the key wins and the counter clears.
- Bytes arriving in GUARDA are consumed by the filter only. A make code there is dropped.

## Timing
- Reset values: state ESPERA, `descartar`=0, counter=0, `dato_tecla`=0x00, `estado_tipo_dato`=0, `salvar`=0, `ocupado`=0, `fin_tiempo`=0.
- A byte with `rx_listo` high at edge k takes effect on registered outputs from cycle k+1.
- Enter accepted at edge k gives:
  - `salvar`=1 during cycle k+1 only;
  - `estado_tipo_dato` and `dato_tecla` stable across that cycle;
  - `estado_tipo_dato`=0 from cycle k+2.
- `fin_tiempo` is registered and is high for the one cycle after the expiry edge.
- Back-to-back `rx_listo` on consecutive cycles must be handled with no byte lost.
- Reset asserted mid-dialogue returns all outputs to their reset values immediately, without waiting for a clock edge. No `salvar` occurs.

## Structure
- Shared package `teclado_pkg` holds:
  - the scan-code localparams (G, Enter, Esc, digits 0–3, F0, E0), shared with the gain decoder;
  - the FSM state encoding (3-bit: ESPERA, SEL_GANANCIA, SEL_VALOR, CONFIRMA, GUARDA).
- Sub-module `temporizador_espera`:
  - parameter TIMEOUT_CICLOS; inputs `habilitar` and `limpiar`; output `expiro` tick;
  - counter width $clog2(TIMEOUT_CICLOS).
- The benches override TIMEOUT_CICLOS=16.

## Test plan
1. Stream 34, F0 34, 1E, F0 1E, 26, F0 26, 5A, F0 5A → exactly one `salvar` pulse with `estado_tipo_dato`=2 and `dato_tecla`=0x26; `ocupado` falls the cycle after.
2. Stream 34, 16, 45, 16, 5A (value key changed in CONFIRMA) → `salvar` with `estado_tipo_dato`=1 and `dato_tecla`=0x16.
3. Stream 34, 26, then silence for 16 cycles → `fin_tiempo` pulses once, no `salvar`, `estado_tipo_dato`=0.
4. Stream 34, F0 16, 16, 45, 76 → the break-prefixed 16 is ignored; Esc aborts; no `salvar`; state ESPERA.
5. Stream 34, 1E, 45, E0 5A on consecutive cycles → `salvar` with `estado_tipo_dato`=2 and `dato_tecla`=0x45.
6. Stream 34, 16, 45, then drive `rst`=0 mid-cycle → all outputs read 0x00/0 before the next edge; after release, a lone 5A produces no `salvar`.
